// File: rtl/dff_share_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dff_share_pkg
// Description : Shared types, default widths and the round-robin pick
//               function used by the shared-register arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dff_share_pkg;

  // Arbiter FSM encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNTW  = 16;

  // Upper bounds so the pick function can work on fixed-size vectors
  localparam int MAX_NREQ = 16;
  localparam int MAX_IDW  = 4;

  typedef struct packed {
    logic               any;
    logic [MAX_IDW-1:0] idx;
  } rr_pick_t;

  // Rotate the request vector so ptr lands at bit 0, take the lowest set bit,
  // then rotate the found position back into requester numbering.
  function automatic rr_pick_t rr_pick(input logic [MAX_NREQ-1:0] req,
                                       input logic [MAX_IDW-1:0]  ptr,
                                       input int                  nreq);
    rr_pick_t            res;
    logic [MAX_NREQ-1:0] rot;
    int                  src;
    int                  k;
    int                  w;
    logic                found;
    rot   = '0;
    k     = 0;
    found = 1'b0;
    for (int i = 0; i < MAX_NREQ; i++) begin
      if (i < nreq) begin
        src = int'(ptr) + i;
        if (src >= nreq) src = src - nreq;
        rot[i] = req[src[MAX_IDW-1:0]];
      end
    end
    for (int i = MAX_NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        k     = i;
        found = 1'b1;
      end
    end
    w = int'(ptr) + k;
    if (w >= nreq) w = w - nreq;
    res.any = found;
    res.idx = w[MAX_IDW-1:0];
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : rr_prio_enc
// Description : Combinational rotating priority encoder. Returns the first
//               requester at or above ptr (wrapping) and whether any request
//               is pending.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_prio_enc
  import dff_share_pkg::*;
#(
  parameter  int NREQ = DEF_NREQ,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  winner,
  output logic            any_req
);

  logic [MAX_NREQ-1:0] req_ext;
  logic [MAX_IDW-1:0]  ptr_ext;
  rr_pick_t            pick;

  // Widen to the fixed package size and evaluate the round-robin pick
  always_comb begin
    req_ext = '0;
    ptr_ext = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ext[i] = req[i];
    end
    ptr_ext[IDW-1:0] = ptr;
    pick    = rr_pick(req_ext, ptr_ext, NREQ);
    winner  = pick.idx[IDW-1:0];
    any_req = pick.any;
  end

endmodule
`default_nettype wire

// File: rtl/dff_share_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dff_share_rr_arbiter
// Description : One WIDTH-bit register shared by NREQ requesters. Round-robin
//               arbitration, IDLE -> WRITE -> ACK per transfer, one-cycle ack
//               pulse and a wrapping committed-write counter.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_share_rr_arbiter
  import dff_share_pkg::*;
#(
  parameter  int NREQ  = DEF_NREQ,
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int CNTW  = DEF_CNTW,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] din,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      q,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy,
  output logic [CNTW-1:0]       wr_cnt
);

  state_t           state;
  state_t           state_nxt;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   winner;
  logic             any_req;
  logic             do_grant;
  logic             do_write;
  logic             do_done;
  logic [NREQ-1:0]  grant_onehot;
  logic [IDW-1:0]   ptr_nxt;
  logic [WIDTH-1:0] din_arr [NREQ];

  rr_prio_enc #(
    .NREQ (NREQ)
  ) u_enc (
    .req     (req),
    .ptr     (ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  for (genvar g = 0; g < NREQ; g++) begin : g_din_split
    assign din_arr[g] = din[g*WIDTH +: WIDTH];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: requests only matter in IDLE; WRITE and ACK last one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = WRITE;
      WRITE:   state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: per-state load strobes for the registered outputs
  always_comb begin
    do_grant = (state == IDLE) && any_req;
    do_write = (state == WRITE);
    do_done  = (state == ACK);
  end

  // One-hot of the served requester and the pointer just past it
  always_comb begin
    grant_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant_onehot[i] = (grant_id == IDW'(i));
    end
    ptr_nxt = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
  end

  // Shared register, handshake outputs, pointer and counter
  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= '0;
      ack      <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      wr_cnt   <= '0;
      ptr      <= '0;
    end else begin
      if (do_grant) begin
        grant_id <= winner;
        busy     <= 1'b1;
      end
      if (do_write) begin
        q      <= din_arr[grant_id];
        ack    <= grant_onehot;
        wr_cnt <= wr_cnt + 1'b1;
        ptr    <= ptr_nxt;
      end
      if (do_done) begin
        ack  <= '0;
        busy <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dff_share_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dff_share_rr_arbiter
// Description : Self-checking bench for dff_share_rr_arbiter. Expected writes
//               are queued when stimulus is applied and checked on each ack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dff_share_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] din;
  logic [3:0]  ack;
  logic [7:0]  q;
  logic [1:0]  grant_id;
  logic        busy;
  logic [15:0] wr_cnt;

  typedef struct {
    logic [3:0]  ack;
    logic [7:0]  q;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] exp_cnt;
  int          n_checks;
  int          n_fail;

  dff_share_rr_arbiter #(
    .NREQ  (4),
    .WIDTH (8),
    .CNTW  (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .din      (din),
    .ack      (ack),
    .q        (q),
    .grant_id (grant_id),
    .busy     (busy),
    .wr_cnt   (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every ack pulse must match the oldest queued write
  always @(negedge clk) begin
    if (ack !== 4'b0000) begin
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_ack: got ack=%b expected no ack", ack);
      end else begin
        mon_e = sb.pop_front();
        n_checks++;
        if (ack !== mon_e.ack) begin n_fail++; $display("FAIL sb_ack: got %b expected %b", ack, mon_e.ack); end
        n_checks++;
        if (q !== mon_e.q) begin n_fail++; $display("FAIL sb_q: got %h expected %h", q, mon_e.q); end
        n_checks++;
        if (wr_cnt !== mon_e.cnt) begin n_fail++; $display("FAIL sb_wr_cnt: got %0d expected %0d", wr_cnt, mon_e.cnt); end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [3:0] a, input logic [7:0] d);
    exp_t e;
    exp_cnt = exp_cnt + 16'd1;
    e.ack = a;
    e.q   = d;
    e.cnt = exp_cnt;
    sb.push_back(e);
  endtask

  // Requesters drop req once acked; stop when idle with nothing outstanding
  task automatic run_handshake(input int max_cyc);
    for (int k = 0; k < max_cyc; k++) begin
      tick();
      req = req & ~ack;
      if (sb.size() == 0 && !busy && ack == 4'b0000) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'hF; din = 32'h4433_2211;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++; if (q !== 8'h00) begin n_fail++; $display("FAIL reset_q: got %h expected 00", q); end
      n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b expected 0000", ack); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
      n_checks++; if (wr_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_wr_cnt: got %0d expected 0", wr_cnt); end
    end
    rst = 1'b0; req = 4'h0; exp_cnt = 16'd0;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single();
    din[15:8] = 8'hA5;
    push_exp(4'b0010, 8'hA5);
    req = 4'b0010;
    tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_t1: got %b expected 1", busy); end
    n_checks++; if (grant_id !== 2'd1) begin n_fail++; $display("FAIL single_grant_t1: got %0d expected 1", grant_id); end
    n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL single_ack_t1: got %b expected 0000", ack); end
    tick();
    n_checks++; if (q !== 8'hA5) begin n_fail++; $display("FAIL single_q_t2: got %h expected a5", q); end
    n_checks++; if (ack !== 4'b0010) begin n_fail++; $display("FAIL single_ack_t2: got %b expected 0010", ack); end
    n_checks++; if (wr_cnt !== 16'd1) begin n_fail++; $display("FAIL single_cnt_t2: got %0d expected 1", wr_cnt); end
    req = 4'b0000;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_t3: got %b expected 0", busy); end
    n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL single_ack_t3: got %b expected 0000", ack); end
    tick();
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL single_pending: got %0d expected 0", sb.size()); end
  endtask

  task automatic test_contention();
    int ack_cyc[$];
    rst = 1'b1; req = 4'h0;
    tick();
    rst = 1'b0; exp_cnt = 16'd0;
    din = 32'h4433_2211;
    push_exp(4'b0001, 8'h11);
    push_exp(4'b0010, 8'h22);
    push_exp(4'b0100, 8'h33);
    push_exp(4'b1000, 8'h44);
    req = 4'hF;
    for (int k = 0; k < 24; k++) begin
      tick();
      if (ack != 4'b0000) begin
        ack_cyc.push_back(k);
        req = req & ~ack;
      end
      if (sb.size() == 0 && !busy && ack == 4'b0000) break;
    end
    n_checks++; if (ack_cyc.size() != 4) begin n_fail++; $display("FAIL contention_ack_count: got %0d expected 4", ack_cyc.size()); end
    for (int j = 1; j < ack_cyc.size(); j++) begin
      n_checks++;
      if (ack_cyc[j] - ack_cyc[j-1] != 3) begin n_fail++; $display("FAIL contention_spacing: got %0d expected 3", ack_cyc[j] - ack_cyc[j-1]); end
    end
    n_checks++; if (q !== 8'h44) begin n_fail++; $display("FAIL contention_q: got %h expected 44", q); end
    n_checks++; if (wr_cnt !== 16'd4) begin n_fail++; $display("FAIL contention_cnt: got %0d expected 4", wr_cnt); end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL contention_pending: got %0d expected 0", sb.size()); end
  endtask

  task automatic test_fairness();
    din[23:16] = 8'h77;
    push_exp(4'b0100, 8'h77);
    req = 4'b0100;
    run_handshake(12);
    din[31:24] = 8'h99; din[7:0] = 8'h12;
    push_exp(4'b1000, 8'h99);
    push_exp(4'b0001, 8'h12);
    req = 4'b1001;
    run_handshake(20);
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL fairness_pending: got %0d expected 0", sb.size()); end
    n_checks++; if (q !== 8'h12) begin n_fail++; $display("FAIL fairness_q: got %h expected 12", q); end
  endtask

  task automatic test_withdraw();
    logic [15:0] prev_cnt;
    prev_cnt = exp_cnt;
    din[23:16] = 8'hC3;
    push_exp(4'b0100, 8'hC3);
    req = 4'b0100;
    tick();
    req = 4'b0000;
    tick();
    n_checks++; if (ack !== 4'b0100) begin n_fail++; $display("FAIL withdraw_ack: got %b expected 0100", ack); end
    n_checks++; if (q !== 8'hC3) begin n_fail++; $display("FAIL withdraw_q: got %h expected c3", q); end
    n_checks++; if (wr_cnt !== prev_cnt + 16'd1) begin n_fail++; $display("FAIL withdraw_cnt: got %0d expected %0d", wr_cnt, prev_cnt + 16'd1); end
    tick(); tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL withdraw_busy: got %b expected 0", busy); end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL withdraw_pending: got %0d expected 0", sb.size()); end
  endtask

  task automatic test_mid_reset();
    din[15:8] = 8'h5A;
    req = 4'b0010;
    tick();
    n_checks++; if (grant_id !== 2'd1) begin n_fail++; $display("FAIL midrst_grant: got %0d expected 1", grant_id); end
    rst = 1'b1; req = 4'b0000;
    tick();
    n_checks++; if (q !== 8'h00) begin n_fail++; $display("FAIL midrst_q: got %h expected 00", q); end
    n_checks++; if (wr_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_cnt: got %0d expected 0", wr_cnt); end
    n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL midrst_ack: got %b expected 0000", ack); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    rst = 1'b0; exp_cnt = 16'd0;
    tick(); tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: got %b expected 0", busy); end
    din[7:0] = 8'h3C;
    push_exp(4'b0001, 8'h3C);
    push_exp(4'b0010, 8'h5A);
    req = 4'b1010 | 4'b0001;
    req = 4'b0011;
    tick();
    n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL midrst_regrant: got %0d expected 0", grant_id); end
    run_handshake(20);
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL midrst_pending: got %0d expected 0", sb.size()); end
    n_checks++; if (wr_cnt !== 16'd2) begin n_fail++; $display("FAIL midrst_final_cnt: got %0d expected 2", wr_cnt); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_cnt  = 16'd0;
    rst      = 1'b1;
    req      = 4'h0;
    din      = 32'h0;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_withdraw();
    test_mid_reset();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
